cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//  Operands are split into STAGES equal segments. Each pipeline stage adds one segment:
//  4-bit lookahead groups inside the segment, group carries rippled within the stage.
//  It is the throughput datapath adder for the ALU and FP-mantissa paths. It replaces the
//  single-cycle 32-bit adder wherever timing or carry-in/flags are needed.
// PARAMETERS
//  WIDTH   32  operand/sum width; must be a multiple of STAGES*4
//  STAGES  2   pipeline depth in cycles (1..8); segment width SEG = WIDTH/STAGES
//  TAG_W   4   width of the sideband tag carried alongside each operation
// PORTS
//  i_clk    in   1      clock; all flops on the rising edge
//  i_rst    in   1      reset, synchronous, active-high
//  i_valid  in   1      input operation valid
//  o_ready  out  1      block can accept an input this cycle
//  i_a      in   WIDTH  operand A
//  i_b      in   WIDTH  operand B
//  i_cin    in   1      carry-in, add mode only
//  i_sub    in   1      1 = A - B (A + ~B + 1), i_cin ignored
//  i_tag    in   TAG_W  sideband, returned unmodified with the result
//  o_valid  out  1      result valid
//  i_ready  in   1      downstream accepts the result
//  o_sum    out  WIDTH  result, modulo 2^WIDTH
//  o_cout   out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//  o_ovf    out  1      signed two's-complement overflow
//  o_zero   out  1      o_sum == 0
//  o_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (sync): all stage valid bits, o_valid, o_sum, o_cout, o_ovf, o_tag = 0; o_zero = 0.
//    Reset while data is in flight discards it; the first cycle after reset has o_ready = 1.
//  - Global advance: adv = ~o_valid | i_ready; o_ready = adv (combinational, no skid buffer).
//  - Input is accepted on i_valid & o_ready. With adv = 0, every stage holds data and valid.
//  - Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] from the carry registered by stage k-1.
//    Stage 0 carry-in = i_sub ? 1 : i_cin.
//  - B operand: i_b is inverted at capture when i_sub = 1.
//  - Upper, not-yet-added A/B bits travel in the pipeline registers with the partial sum.
//  - Latency: exactly STAGES cycles from acceptance to o_valid with no stall.
//    Throughput is 1 op/cycle. Ordering is strictly in order.
//  - Bubbles: an empty stage advances as valid = 0. Data flops may hold stale values.
//    o_* data is only meaningful while o_valid = 1.
//  - Flags come from the final stage and are registered with o_sum:
//    o_cout = carry out of the MSB.
//    o_ovf = carry into MSB ^ carry out of MSB.
//    o_zero = ~|o_sum.
//  - Boundaries:
//    - Full pipeline with i_ready = 0: o_ready = 0; o_valid and o_* are stable until taken.
//    - i_ready = 1 with a full pipeline: the new input is accepted in the same cycle the
//      oldest result leaves (no bubble).
//    - All-ones + 1 wraps to 0 with o_cout = 1 and o_zero = 1.
//  - STAGES = 1: purely registered output, latency 1.
//  - Illegal WIDTH/STAGES combination: $error at elaboration.
// TESTING
//  - Add, WIDTH=32, STAGES=2: A=0x0000_FFFF, B=0x0000_0001, cin=0 -> 2 cycles later
//    sum=0x0001_0000, cout=0, ovf=0, zero=0.
//  - Carry across a stage boundary: A=0xFFFF_FFFF, B=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0.
//  - Sub: A=5, B=7 -> sum=0xFFFF_FFFE, cout=0. Then A=0x8000_0000, B=1 -> sum=0x7FFF_FFFF, ovf=1.
//  - Back-to-back 100 random ops with random i_ready stalls and tags:
//    - every result matches the reference model, in order, with the correct tag;
//    - no drops or duplicates;
//    - o_* stay stable while o_valid & ~i_ready.
//  - Fill the pipeline with i_ready = 0 -> o_ready drops after STAGES accepts.
//    Release i_ready -> 1 result/cycle.
//  - Assert i_rst mid-stream with 2 ops in flight -> next cycle o_valid = 0 and o_ready = 1.
//    No stale result ever appears. Repeat all scenarios for WIDTH=64, STAGES=4 and STAGES=1.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//   Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//   The operands are split into STAGES equal segments of SEG = WIDTH/STAGES
//   bits. Pipeline stage k adds segment k using 4-bit lookahead groups whose
//   group carries ripple inside the stage. The carry out of each segment is
//   registered and feeds the next stage. The not-yet-added upper A/B bits
//   travel down the pipeline next to the growing partial sum.
//
//   Flow control uses one global advance: adv = ~o_valid | i_ready. When adv
//   is low, every stage holds its data and valid bit. There is no skid buffer,
//   so o_ready is simply adv.
//
// Parameters
//   WIDTH   operand/sum width, a multiple of STAGES*4
//   STAGES  pipeline depth in cycles (1..8)
//   TAG_W   sideband tag width
//
// Ports
//   i_clk, i_rst       rising-edge clock, synchronous active-high reset
//   i_valid / o_ready  input handshake
//   i_a, i_b           operands
//   i_cin              carry-in (add mode only)
//   i_sub              1 = A - B, computed as A + ~B + 1 (i_cin ignored)
//   i_tag              sideband, returned unchanged with the result
//   o_valid / i_ready  output handshake
//   o_sum              result modulo 2^WIDTH
//   o_cout             carry out of the MSB (sub: 1 = no borrow)
//   o_ovf              signed two's-complement overflow
//   o_zero             o_sum == 0
//   o_tag              tag of this result
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic [TAG_W-1:0] o_tag
);

  localparam int SEG    = (STAGES > 0) ? WIDTH / STAGES : WIDTH;
  localparam int GROUPS = SEG / 4;

  if (STAGES < 1 || STAGES > 8 || (WIDTH % (STAGES * 4)) != 0) begin : g_param_check
    $error("cla_adder_pipe: WIDTH (%0d) must be a multiple of STAGES*4 with STAGES in 1..8 (STAGES=%0d)",
           WIDTH, STAGES);
  end

  typedef struct packed {
    logic [SEG-1:0] sum;
    logic           cout;
  } seg_res_t;

  // One segment: each 4-bit group derives all of its internal carries from the
  // group carry-in alone (lookahead); group carries then ripple group to group.
  function automatic seg_res_t cla_seg(input logic [SEG-1:0] a,
                                       input logic [SEG-1:0] b,
                                       input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    seg_res_t       r;
    g = a & b;
    p = a ^ b;
    // NOTE: give every combinationally computed variable a full default before
    // any partial or conditional update, otherwise synthesis infers a latch.
    c    = '0;
    c[0] = cin;
    for (int grp = 0; grp < GROUPS; grp++) begin
      c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
      c[4*grp+2] = g[4*grp+1]
                 | (p[4*grp+1] & g[4*grp])
                 | (p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+3] = g[4*grp+2]
                 | (p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+4] = g[4*grp+3]
                 | (p[4*grp+3] & g[4*grp+2])
                 | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
    end
    r.sum  = p ^ c[SEG-1:0];
    r.cout = c[SEG];
    return r;
  endfunction

  logic adv;

  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit IS_LAST = (k == STAGES - 1);
    // Operand bits still to be added when entering stage k.
    localparam int IN_W    = WIDTH - k * SEG;

    logic [IN_W-1:0]      opa_in;
    logic [IN_W-1:0]      opb_in;
    logic                 cin_in;
    logic                 vld_in;
    logic [TAG_W-1:0]     tag_in;
    seg_res_t             res;
    logic [(k+1)*SEG-1:0] sum_d;

    logic                 vld_q;
    logic                 c_q;
    logic [TAG_W-1:0]     tag_q;
    logic [(k+1)*SEG-1:0] sum_q;

    if (k == 0) begin : g_head
      // Subtraction is folded in at capture: invert B and force carry-in.
      assign opa_in = i_a;
      assign opb_in = i_sub ? ~i_b : i_b;
      assign cin_in = i_sub | i_cin;
      assign vld_in = i_valid;
      assign tag_in = i_tag;
      assign sum_d  = res.sum;
    end else begin : g_body
      assign opa_in = g_stage[k-1].g_ops.opa_q;
      assign opb_in = g_stage[k-1].g_ops.opb_q;
      assign cin_in = g_stage[k-1].c_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign tag_in = g_stage[k-1].tag_q;
      assign sum_d  = {res.sum, g_stage[k-1].sum_q};
    end

    assign res = cla_seg(opa_in[SEG-1:0], opb_in[SEG-1:0], cin_in);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= vld_in;
      end
    end

    // NOTE: only the valid bits and the visible output stage are reset; the
    // inner data flops are qualified by valid, so resetting them buys nothing.
    always_ff @(posedge i_clk) begin
      if (i_rst && IS_LAST) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        tag_q <= '0;
      end else if (adv) begin
        sum_q <= sum_d;
        c_q   <= res.cout;
        tag_q <= tag_in;
      end
    end

    if (!IS_LAST) begin : g_ops
      logic [IN_W-SEG-1:0] opa_q;
      logic [IN_W-SEG-1:0] opb_q;
      always_ff @(posedge i_clk) begin
        if (adv) begin
          opa_q <= opa_in[IN_W-1:SEG];
          opb_q <= opb_in[IN_W-1:SEG];
        end
      end
    end else begin : g_tail
      logic c_msb;
      logic ovf_q;
      logic zero_q;
      // Carry into the MSB recovered from the MSB's sum and operand bits.
      assign c_msb = res.sum[SEG-1] ^ opa_in[SEG-1] ^ opb_in[SEG-1];
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= c_msb ^ res.cout;
          zero_q <= ~|sum_d;
        end
      end
    end
  end

  assign o_valid = g_stage[STAGES-1].vld_q;
  assign o_sum   = g_stage[STAGES-1].sum_q;
  assign o_cout  = g_stage[STAGES-1].c_q;
  assign o_tag   = g_stage[STAGES-1].tag_q;
  assign o_ovf   = g_stage[STAGES-1].g_tail.ovf_q;
  assign o_zero  = g_stage[STAGES-1].g_tail.zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_pipe
//   Three instances: 32-bit/2 stages, 64-bit/4 stages, 32-bit/1 stage.
//   Directed table vectors, pipeline fill/stall/release, mid-stream reset and a
//   randomized handshake stream against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_cla_adder_pipe;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        in_valid [NDUT];
  logic        in_cin   [NDUT];
  logic        in_sub   [NDUT];
  logic        rdy      [NDUT];
  logic [63:0] in_a     [NDUT];
  logic [63:0] in_b     [NDUT];
  logic [3:0]  in_tag   [NDUT];

  wire         out_ready [NDUT];
  wire         out_valid [NDUT];
  wire         out_cout  [NDUT];
  wire         out_ovf   [NDUT];
  wire         out_zero  [NDUT];
  wire  [3:0]  out_tag   [NDUT];
  wire  [63:0] out_sum   [NDUT];

  wire  [31:0] sum0;
  wire  [63:0] sum1;
  wire  [31:0] sum2;

  assign out_sum[0] = {32'h0, sum0};
  assign out_sum[1] = sum1;
  assign out_sum[2] = {32'h0, sum2};

  cla_adder_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_w32_s2 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
    .i_a(in_a[0][31:0]), .i_b(in_b[0][31:0]), .i_cin(in_cin[0]), .i_sub(in_sub[0]),
    .i_tag(in_tag[0]), .o_valid(out_valid[0]), .i_ready(rdy[0]), .o_sum(sum0),
    .o_cout(out_cout[0]), .o_ovf(out_ovf[0]), .o_zero(out_zero[0]), .o_tag(out_tag[0])
  );

  cla_adder_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(4)) u_w64_s4 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
    .i_a(in_a[1]), .i_b(in_b[1]), .i_cin(in_cin[1]), .i_sub(in_sub[1]),
    .i_tag(in_tag[1]), .o_valid(out_valid[1]), .i_ready(rdy[1]), .o_sum(sum1),
    .o_cout(out_cout[1]), .o_ovf(out_ovf[1]), .o_zero(out_zero[1]), .o_tag(out_tag[1])
  );

  cla_adder_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u_w32_s1 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid[2]), .o_ready(out_ready[2]),
    .i_a(in_a[2][31:0]), .i_b(in_b[2][31:0]), .i_cin(in_cin[2]), .i_sub(in_sub[2]),
    .i_tag(in_tag[2]), .o_valid(out_valid[2]), .i_ready(rdy[2]), .o_sum(sum2),
    .o_cout(out_cout[2]), .o_ovf(out_ovf[2]), .o_zero(out_zero[2]), .o_tag(out_tag[2])
  );

  function automatic int w_of(input int n);
    return (n == 1) ? 64 : 32;
  endfunction

  function automatic int s_of(input int n);
    case (n)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: plain wide arithmetic, overflow from operand/result signs.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    res_t       r;
    logic [3:0] tag;
  } exp_t;

  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] m;
    logic [63:0] am;
    logic [63:0] bb;
    logic [64:0] full;
    res_t        r;
    m    = (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
    am   = a & m;
    bb   = (sub ? ~b : b) & m;
    full = {1'b0, am} + {1'b0, bb} + {64'h0, (sub | cin)};
    r.sum  = full[63:0] & m;
    r.cout = full[w];
    r.ovf  = (am[w-1] == bb[w-1]) && (r.sum[w-1] != am[w-1]);
    r.zero = (r.sum == 64'h0);
    return r;
  endfunction

  function automatic exp_t mk(input int n, input logic [63:0] a, input logic [63:0] b,
                              input logic cin, input logic sub, input logic [3:0] tg);
    exp_t e;
    e.r   = model(w_of(n), a, b, cin, sub);
    e.tag = tg;
    return e;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int n, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s [dut %0d] t=%0t: got %h, want %h", name, n, $time, act, exp);
    end
  endtask

  task automatic cmp_result(input string pfx, input int n, input exp_t e);
    check({pfx, "_sum"},   n, out_sum[n], e.r.sum);
    check({pfx, "_flags"}, n, {61'h0, out_cout[n], out_ovf[n], out_zero[n]},
          {61'h0, e.r.cout, e.r.ovf, e.r.zero});
    check({pfx, "_tag"},   n, {60'h0, out_tag[n]}, {60'h0, e.tag});
  endtask

  task automatic drive(input int n, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub, input logic [3:0] tg);
    in_valid[n] = v;
    in_a[n]     = a;
    in_b[n]     = b;
    in_cin[n]   = cin;
    in_sub[n]   = sub;
    in_tag[n]   = tg;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vec(input int n, input vec_t v, input logic [3:0] tg);
    int lat;
    @(negedge clk);
    rdy[n] = 1'b1;
    drive(n, 1'b1, v.a, v.b, v.cin, v.sub, tg);
    #1;
    check("vec_accept", n, {63'h0, out_ready[n]}, 64'h1);
    @(negedge clk);
    in_valid[n] = 1'b0;
    #1;
    lat = 1;
    while (!out_valid[n] && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("vec_latency", n, 64'(lat), 64'(s_of(n)));
    check("vec_sum",     n, out_sum[n], v.sum);
    check("vec_flags",   n, {61'h0, out_cout[n], out_ovf[n], out_zero[n]},
          {61'h0, v.cout, v.ovf, v.zero});
    check("vec_tag",     n, {60'h0, out_tag[n]}, {60'h0, tg});
  endtask

  // ---------------------------------------------------------------------------
  // Fill with i_ready low, stall, then release with a same-cycle accept
  // ---------------------------------------------------------------------------
  task automatic fill_test(input int n);
    exp_t        q[$];
    exp_t        e;
    int          s;
    int          acc;
    bit          stalled;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tg;
    logic [63:0] snap_sum;
    logic [63:0] snap_misc;
    s       = s_of(n);
    acc     = 0;
    stalled = 1'b0;
    a       = '0;
    b       = '0;
    tg      = '0;
    for (int c = 0; c < s + 3 && !stalled; c++) begin
      @(negedge clk);
      rdy[n] = 1'b0;
      a  = rand64();
      b  = rand64();
      tg = 4'(acc + 1);
      drive(n, 1'b1, a, b, 1'b0, 1'b0, tg);
      #1;
      if (out_ready[n]) begin
        q.push_back(mk(n, a, b, 1'b0, 1'b0, tg));
        acc++;
      end else begin
        stalled = 1'b1;
      end
    end
    check("fill_accepts", n, 64'(acc), 64'(s));
    check("fill_valid",   n, {63'h0, out_valid[n]}, 64'h1);
    snap_sum  = out_sum[n];
    snap_misc = {56'h0, out_cout[n], out_ovf[n], out_zero[n], out_tag[n], out_valid[n]};
    repeat (2) begin
      @(negedge clk);
      #1;
      check("stall_sum",   n, out_sum[n], snap_sum);
      check("stall_misc",  n, {56'h0, out_cout[n], out_ovf[n], out_zero[n], out_tag[n],
                               out_valid[n]}, snap_misc);
      check("stall_ready", n, {63'h0, out_ready[n]}, 64'h0);
    end
    // The pending input goes in on the same edge the oldest result leaves.
    @(negedge clk);
    rdy[n] = 1'b1;
    #1;
    check("release_ready", n, {63'h0, out_ready[n]}, 64'h1);
    q.push_back(mk(n, a, b, 1'b0, 1'b0, tg));
    for (int j = 0; j <= s; j++) begin
      if (j > 0) begin
        @(negedge clk);
        in_valid[n] = 1'b0;
        #1;
      end
      check("drain_valid", n, {63'h0, out_valid[n]}, 64'h1);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp_result("drain", n, e);
      end
    end
    @(negedge clk);
    in_valid[n] = 1'b0;
    #1;
    check("drain_empty", n, {63'h0, out_valid[n]}, 64'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Reset with work in flight
  // ---------------------------------------------------------------------------
  task automatic reset_test(input int n);
    int seen;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rdy[n] = 1'b0;
      drive(n, 1'b1, rand64(), rand64(), 1'b0, 1'b0, 4'(c + 9));
    end
    @(negedge clk);
    in_valid[n] = 1'b0;
    rdy[n]      = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", n, {63'h0, out_valid[n]}, 64'h0);
    check("rst_ready", n, {63'h0, out_ready[n]}, 64'h1);
    seen = 0;
    for (int c = 0; c < s_of(n) + 3; c++) begin
      @(negedge clk);
      #1;
      if (out_valid[n]) seen++;
    end
    check("rst_no_stale", n, 64'(seen), 64'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Randomized stream with random stalls, scoreboarded in order
  // ---------------------------------------------------------------------------
  task automatic random_test(input int n, input int nops);
    exp_t        q[$];
    exp_t        e;
    int          sent;
    int          got;
    int          cyc;
    bit          held;
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  tg;
    logic [63:0] snap_sum;
    logic [63:0] snap_misc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    held = 1'b0;
    snap_sum  = '0;
    snap_misc = '0;
    while (got < nops && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      rdy[n] = ($urandom_range(0, 3) != 0);
      v   = (sent < nops) && ($urandom_range(0, 4) != 0);
      a   = rand64();
      b   = rand64();
      case ($urandom_range(0, 7))
        0:       begin a = '1; b = '0; end
        1:       begin a = '1; b = 64'h1; end
        2:       b = a;
        default: ;
      endcase
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      tg  = 4'(sent);
      drive(n, v, a, b, cin, sub, tg);
      #1;
      check("ready_rule", n, {63'h0, out_ready[n]}, {63'h0, (~out_valid[n] | rdy[n])});
      if (held) begin
        check("hold_sum",  n, out_sum[n], snap_sum);
        check("hold_misc", n, {56'h0, out_cout[n], out_ovf[n], out_zero[n], out_tag[n],
                               out_valid[n]}, snap_misc);
        held = 1'b0;
      end
      if (out_valid[n]) begin
        if (rdy[n]) begin
          check("rand_expected", n, {63'h0, (q.size() != 0)}, 64'h1);
          if (q.size() != 0) begin
            e = q.pop_front();
            cmp_result("rand", n, e);
          end
          got++;
        end else begin
          held      = 1'b1;
          snap_sum  = out_sum[n];
          snap_misc = {56'h0, out_cout[n], out_ovf[n], out_zero[n], out_tag[n], out_valid[n]};
        end
      end
      if (v && out_ready[n]) begin
        q.push_back(mk(n, a, b, cin, sub, tg));
        sent++;
      end
    end
    check("rand_count",    n, 64'(got), 64'(nops));
    check("rand_leftover", n, 64'(q.size()), 64'h0);
    @(negedge clk);
    in_valid[n] = 1'b0;
    rdy[n]      = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    for (int n = 0; n < NDUT; n++) begin
      drive(n, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      rdy[n] = 1'b1;
    end

    tbl.push_back('{32, 64'h0000_FFFF, 64'h1,         1'b0, 1'b0, 64'h0001_0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32, 64'hFFFF_FFFF, 64'h0,         1'b1, 1'b0, 64'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{32, 64'h5,         64'h7,         1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32, 64'h8000_0000, 64'h1,         1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{32, 64'hFFFF_FFFF, 64'h1,         1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{32, 64'h7,         64'h7,         1'b1, 1'b1, 64'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{32, 64'h7FFF_FFFF, 64'h1,         1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0,       1'b1, 1'b0, 1'b1});
    tbl.push_back('{64, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{64, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{64, 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int n = 0; n < NDUT; n++) begin
      check("reset_valid", n, {63'h0, out_valid[n]}, 64'h0);
      check("reset_ready", n, {63'h0, out_ready[n]}, 64'h1);
      check("reset_sum",   n, out_sum[n], 64'h0);
      check("reset_misc",  n, {57'h0, out_cout[n], out_ovf[n], out_zero[n], out_tag[n]}, 64'h0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      for (int n = 0; n < NDUT; n++) begin
        if (w_of(n) == tbl[i].w) run_vec(n, tbl[i], 4'(i));
      end
    end

    for (int n = 0; n < NDUT; n++) begin
      fill_test(n);
      reset_test(n);
      random_test(n, 100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares",
             n_vec, n_miss);
    $fatal(1, "time limit");
  end

endmodule
